// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the MEM-stage access logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 16;
    localparam int RW_DEF = 4;

    localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: issues one req/ack transaction per access,
// holds the request fields stable, captures read data and raises stall.
module mem_req_fsm
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          access,
    input  logic          is_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] rdata_cap
);

    mem_state_e    state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = is_write;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    rdata_d = dmem_rdata;
                end
            end
            // EX/MEM advances on the DONE edge, so IDLE sees the next instruction.
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign stall      = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);
    assign done       = (state_q == ST_DONE);
    assign rdata_cap  = rdata_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: LW/SW data-memory access over req/ack plus the MEM/WB registers.
// Optional store-data forwarding from WB is enabled by defining MEM2MEM_FWD_EN.
module mem_stage_access
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          exm_mem_read,
    input  logic          exm_mem_write,
    input  logic          exm_reg_write,
    input  logic          exm_mem_to_reg,
    input  logic          exm_halt,
    input  logic [RW-1:0] exm_rd,
    input  logic [RW-1:0] exm_rt,
    input  logic [DW-1:0] exm_rt_val,
    input  logic [DW-1:0] exm_alu_data,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall,
    output logic          mw_reg_write,
    output logic          mw_mem_to_reg,
    output logic          mw_halt,
    output logic [RW-1:0] mw_rd,
    output logic [DW-1:0] mw_mem_data,
    output logic [DW-1:0] mw_alu_data
);

    logic          access;
    logic [DW-1:0] store_data;
    logic          done;
    logic [DW-1:0] rdata_cap;

    assign access = exm_mem_read | exm_mem_write;

`ifdef MEM2MEM_FWD_EN
    logic fwd_store;
    assign fwd_store  = exm_mem_write & wb_reg_write & (wb_rd == exm_rt) &
                        (wb_rd != RW'(REG_ZERO));
    assign store_data = fwd_store ? wb_data : exm_rt_val;
`else
    logic unused_wb;
    assign unused_wb  = ^{wb_reg_write, wb_rd, wb_data, exm_rt};
    assign store_data = exm_rt_val;
`endif

    mem_req_fsm #(.DW(DW), .AW(AW)) u_req_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .access     (access),
        .is_write   (exm_mem_write),
        .addr       (exm_alu_data[AW-1:0]),
        .wdata      (store_data),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .stall      (stall),
        .done       (done),
        .rdata_cap  (rdata_cap)
    );

    logic          reg_write_q, reg_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic          halt_q, halt_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic [DW-1:0] alu_data_q, alu_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
            rd_q         <= '0;
            mem_data_q   <= '0;
            alu_data_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            halt_q       <= halt_d;
            rd_q         <= rd_d;
            mem_data_q   <= mem_data_d;
            alu_data_q   <= alu_data_d;
        end
    end

    // A bubble only needs its side-effecting controls cleared; data fields hold.
    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        halt_d       = halt_q;
        rd_d         = rd_q;
        mem_data_d   = mem_data_q;
        alu_data_d   = alu_data_q;
        if (stall) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            halt_d       = 1'b0;
        end else begin
            reg_write_d  = exm_reg_write;
            mem_to_reg_d = exm_mem_to_reg;
            halt_d       = exm_halt;
            rd_d         = exm_rd;
            alu_data_d   = exm_alu_data;
            if (done) mem_data_d = rdata_cap;
        end
    end

    assign mw_reg_write  = reg_write_q;
    assign mw_mem_to_reg = mem_to_reg_q;
    assign mw_halt       = halt_q;
    assign mw_rd         = rd_q;
    assign mw_mem_data   = mem_data_q;
    assign mw_alu_data   = alu_data_q;

endmodule
